// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// fsm_pkg : shared state encoding, sample type and default timing lengths
// Revision: 1.0
// ============================================================================
package fsm_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SPIKE = 2'd2,
        ST_REFR  = 2'd3
    } state_t;

    typedef logic signed [11:0] sample_t;

    localparam int c_INIT_CYCLES_DEFAULT    = 6;
    localparam int c_REFRACT_CYCLES_DEFAULT = 4;

endpackage : fsm_pkg
`default_nettype wire

// File: rtl/fsm.sv
`default_nettype none
// ============================================================================
// fsm : threshold spike detector with post-reset blanking and refractory time
// Revision: 1.0
// ============================================================================
module fsm
    import fsm_pkg::*;
#(
    parameter int INIT_CYCLES    = c_INIT_CYCLES_DEFAULT,
    parameter int REFRACT_CYCLES = c_REFRACT_CYCLES_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    input  sample_t q,
    input  sample_t soglia,
    output logic    spike
);

    localparam int c_MAX_CYCLES = (INIT_CYCLES > REFRACT_CYCLES) ? INIT_CYCLES : REFRACT_CYCLES;
    localparam int c_CW_RAW     = $clog2(c_MAX_CYCLES);
    // A single-cycle INIT and REFR would give a zero-width counter; keep one bit.
    localparam int c_CW         = (c_CW_RAW < 1) ? 1 : c_CW_RAW;

    localparam logic [c_CW-1:0] c_INIT_LOAD = c_CW'(INIT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_REFR_LOAD = c_CW'(REFRACT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
    localparam logic [c_CW-1:0] c_ZERO      = '0;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            r_spike;
    logic            w_above;

    assign w_above = (q > soglia);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == c_ZERO) w_state_nxt = ST_IDLE;
                else                 w_cnt_nxt   = r_cnt - c_ONE;
            end
            ST_IDLE: begin
                if (w_above) w_state_nxt = ST_SPIKE;
            end
            ST_SPIKE: begin
                if (!w_above) begin
                    w_state_nxt = ST_REFR;
                    w_cnt_nxt   = c_REFR_LOAD;
                end
            end
            ST_REFR: begin
                if (r_cnt == c_ZERO) w_state_nxt = ST_IDLE;
                else                 w_cnt_nxt   = r_cnt - c_ONE;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = c_INIT_LOAD;
            end
        endcase
    end

    // spike is registered from the next state so it is high exactly in SPIKE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= c_INIT_LOAD;
            r_spike <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_spike <= (w_state_nxt == ST_SPIKE);
        end
    end

    assign spike = r_spike;

endmodule : fsm
`default_nettype wire

// File: tb/tb_fsm.sv
`default_nettype none
// ============================================================================
// tb_fsm : randomized and directed checks of fsm against a timeline model
// Revision: 1.0
// ============================================================================
module tb_fsm;
    import fsm_pkg::*;

    localparam int c_INIT = 6;
    localparam int c_REFR = 4;

    logic    clk;
    logic    rst;
    sample_t q;
    sample_t soglia;
    logic    spike;

    int n_checks;
    int n_errors;

    // Model: cycles of blanking still to run, and whether a spike is in progress.
    int   m_blank;
    logic m_spike;

    fsm #(
        .INIT_CYCLES    (c_INIT),
        .REFRACT_CYCLES (c_REFR)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .q      (q),
        .soglia (soglia),
        .spike  (spike)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: spike=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input sample_t qq, input sample_t ss);
        logic above;
        above = (qq > ss);
        if (r) begin
            m_blank = c_INIT;
            m_spike = 1'b0;
        end else if (m_blank > 0) begin
            m_blank--;
            m_spike = 1'b0;
        end else begin
            if (m_spike && !above) m_blank = c_REFR;
            m_spike = above;
        end
    endtask

    // Drive mid-cycle, take one rising edge, check 1 time unit later.
    // exp_const >= 0 additionally pins the DUT to a value fixed by hand.
    task automatic step(input string tag, input logic r, input int qq, input int ss,
                        input int exp_const);
        @(negedge clk);
        rst    = r;
        q      = sample_t'(qq);
        soglia = sample_t'(ss);
        model_edge(r, sample_t'(qq), sample_t'(ss));
        @(posedge clk);
        #1;
        check(tag, spike, m_spike);
        if (exp_const >= 0) check({tag, "_fixed"}, spike, exp_const[0]);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_blank  = c_INIT;
        m_spike  = 1'b0;
        rst      = 1'b1;
        q        = '0;
        soglia   = 12'sd256;

        // Edge 0: last reset edge
        step("reset", 1'b1, 0, 256, 0);
        // Blanking
        step("blank_e1", 1'b0, 0,    256, 0);
        step("blank_e2", 1'b0, 0,    256, 0);
        step("blank_e3", 1'b0, 24,   256, 0);
        step("blank_e4", 1'b0, 1048, 256, 0);
        step("blank_e5", 1'b0, 1048, 256, 0);
        step("blank_e6", 1'b0, 24,   256, 0);
        // Detection
        step("det_e7", 1'b0, 1048, 256, 1);
        step("det_e8", 1'b0, 1048, 256, 1);
        step("det_e9", 1'b0, 88,   256, 0);
        // Refractory
        step("refr_e10", 1'b0, 88,   256, 0);
        step("refr_e11", 1'b0, 1560, 256, 0);
        step("refr_e12", 1'b0, 1560, 256, 0);
        step("refr_e13", 1'b0, 1560, 256, 0);
        step("refr_e14", 1'b0, 1560, 256, 1);
        step("refr_e15", 1'b0, 0,    256, 0);
        step("refr_e16", 1'b0, 0,    256, 0);
        for (int i = 0; i < 3; i++) step("refr_wait", 1'b0, 0, 256, 0);
        // Threshold boundary
        step("equal_1", 1'b0, 256, 256, 0);
        step("equal_2", 1'b0, 256, 256, 0);
        step("above_1", 1'b0, 257, 256, 1);
        step("above_2", 1'b0, 257, 256, 1);
        // Reset mid-spike
        step("rst_mid", 1'b1, 2000, 256, 0);
        for (int i = 0; i < 6; i++) step("rst_blank", 1'b0, 2000, 256, 0);
        step("rst_after", 1'b0, 2000, 256, 1);
        // Signed compare
        step("neg_fall", 1'b0, 0, 256, 0);
        for (int i = 0; i < 4; i++) step("neg_refr", 1'b0, -50, -100, 0);
        step("neg_above", 1'b0, -50,  -100, 1);
        step("neg_exit",  1'b0, -150, -100, 0);
        for (int i = 0; i < 4; i++) step("neg_refr2", 1'b0, -1, -2, 0);
        step("neg_m1_m2", 1'b0, -1, -2, 1);

        // Randomized: q mostly near the threshold, occasional resets and threshold moves
        begin
            int s;
            int qq;
            logic r;
            s = 256;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 49) == 0) s = int'($urandom_range(0, 4095)) - 2048;
                if ($urandom_range(0, 3) == 0) qq = int'($urandom_range(0, 4095)) - 2048;
                else                           qq = s + int'($urandom_range(0, 6)) - 3;
                if (qq > 2047)  qq = 2047;
                if (qq < -2048) qq = -2048;
                r = ($urandom_range(0, 79) == 0);
                step("random", r, qq, s, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fsm
`default_nettype wire
